// File: rtl/pad_command_queue_pkg.sv
// pad_pkg: shared button indices, command type and default timing for the pad command queue
package pad_pkg;
  localparam int NUM_BUTTONS = 11;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_X = 7;
  localparam int BTN_Y = 8;
  localparam int BTN_Z = 9;
  localparam int BTN_START = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY = 20000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef logic [3:0] cmd_t;
  function automatic cmd_t lowest_index(input logic [NUM_BUTTONS-1:0] v);
    lowest_index = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--)
      if (v[k]) lowest_index = cmd_t'(k);
  endfunction
endpackage

// File: rtl/pad_command_queue_if.sv
// pad_command_queue_if: command valid/ready handshake
//   cmd_valid : head of queue holds a command (producer -> consumer)
//   cmd_code  : command code at head (producer -> consumer)
//   cmd_ready : consumer accepts head (consumer -> producer)
interface pad_command_queue_if;
  import pad_pkg::*;
  logic cmd_valid;
  cmd_t cmd_code;
  logic cmd_ready;
  modport master(output cmd_valid, output cmd_code, input cmd_ready);
  modport slave(input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pad_command_queue_debounce_bit.sv
// debounce_bit: 2-flop synchroniser, debounce counter and rising-edge pulse for one button
//   clk, rst_n : clock, async active-low reset
//   din        : raw asynchronous button level
//   level      : debounced level
//   rise       : one-cycle pulse on the cycle level goes 0->1
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      level_d <= level;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign rise = level & ~level_d;
endmodule

// File: rtl/pad_command_queue.sv
// pad_command_queue: debounced, repeating gamepad button events queued as 4-bit commands
//   clock_50   : system clock
//   reset_key  : async active-low reset
//   buttons_in : raw button levels, active-high pressed
//   cmd        : command handshake (master side)
//   held       : debounced button levels
//   overflow   : sticky, an event was lost
module pad_command_queue import pad_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clock_50,
  input  logic reset_key,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  pad_command_queue_if.master cmd,
  output logic [NUM_BUTTONS-1:0] held,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [NUM_BUTTONS-1:0] rise, rep, ev, pending, clr;
  cmd_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
  cmd_t push_code;
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clock_50), .rst_n(reset_key), .din(buttons_in[i]), .level(held[i]), .rise(rise[i])
    );
  end
  // Counter value equals cycles since the rising event; after each repeat it is
  // rewound so the next repeat lands REPEAT_PERIOD cycles later.
  for (genvar i = BTN_UP; i <= BTN_RIGHT; i++) begin : g_rep
    logic [RW-1:0] rcnt;
    assign rep[i] = held[i] && rcnt == RW'(REPEAT_DELAY);
    always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) rcnt <= '0;
      else if (rise[i]) rcnt <= RW'(1);
      else if (!held[i]) rcnt <= '0;
      else if (rep[i]) rcnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      else rcnt <= rcnt + 1'b1;
    end
  end
  assign rep[NUM_BUTTONS-1:BTN_RIGHT+1] = '0;
  assign ev = rise | rep;
  assign pop = cmd.cmd_valid && cmd.cmd_ready;
  // A pop in the same cycle frees a slot even when full.
  assign push = |pending && (count != (AW+1)'(FIFO_DEPTH) || pop);
  assign push_code = lowest_index(pending);
  assign clr = push ? (NUM_BUTTONS'(1) << push_code) : '0;
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      pending <= '0;
      overflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else begin
      pending <= (pending & ~clr) | ev;
      overflow <= overflow | (|(ev & pending & ~clr));
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign cmd.cmd_valid = count != '0;
  assign cmd.cmd_code = mem[rd_ptr];
endmodule

// File: tb/tb_pad_command_queue.sv
// tb_pad_command_queue: directed self-checking bench for pad_command_queue
module tb_pad_command_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] buttons = '0;
  logic [10:0] held;
  logic overflow;
  int errors = 0;
  int checks = 0;
  pad_command_queue_if cif();
  pad_command_queue #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .FIFO_DEPTH(4)
  ) dut (
    .clock_50(clk), .reset_key(rst_n), .buttons_in(buttons), .cmd(cif.master),
    .held(held), .overflow(overflow)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    buttons = '0;
    cif.cmd_ready = 1'b0;
    tick(2);
    checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cif.cmd_valid); end
    checks++; if (cif.cmd_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", cif.cmd_code); end
    checks++; if (held !== 11'h0) begin errors++; $display("FAIL reset_held got=%h exp=0", held); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_press;
    int first = -1;
    int nvalid = 0;
    cif.cmd_ready = 1'b1;
    buttons[4] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      if (cif.cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = n;
        checks++; if (cif.cmd_code !== 4'd4) begin errors++; $display("FAIL press_code got=%0d exp=4", cif.cmd_code); end
      end
      if (n == 20) begin
        checks++; if (held[4] !== 1'b1) begin errors++; $display("FAIL press_held got=%b exp=1", held[4]); end
      end
    end
    buttons[4] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick(1);
      if (cif.cmd_valid === 1'b1) nvalid++;
    end
    checks++; if (first != 8) begin errors++; $display("FAIL press_latency got=%0d exp=8", first); end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL press_valid_cycles got=%0d exp=1", nvalid); end
    checks++; if (held[4] !== 1'b0) begin errors++; $display("FAIL release_held got=%b exp=0", held[4]); end
  endtask

  task automatic test_glitch;
    int seen_held = 0;
    int seen_valid = 0;
    cif.cmd_ready = 1'b1;
    buttons[5] = 1'b1;
    tick(2);
    buttons[5] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      if (held[5] === 1'b1) seen_held++;
      if (cif.cmd_valid === 1'b1) seen_valid++;
    end
    checks++; if (seen_held != 0) begin errors++; $display("FAIL glitch_held got=%0d exp=0", seen_held); end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL glitch_cmd got=%0d exp=0", seen_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL glitch_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_repeat;
    int got [$];
    int exp [6] = '{8, 28, 36, 44, 52, 60};
    cif.cmd_ready = 1'b1;
    buttons[0] = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick(1);
      if (cif.cmd_valid === 1'b1) begin
        got.push_back(n);
        checks++; if (cif.cmd_code !== 4'd0) begin errors++; $display("FAIL repeat_code got=%0d exp=0", cif.cmd_code); end
      end
      if (n == 60) buttons[0] = 1'b0;
    end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL repeat_count got=%0d exp=6", got.size()); end
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      checks++; if (got[j] != exp[j]) begin errors++; $display("FAIL repeat_time[%0d] got=%0d exp=%0d", j, got[j], exp[j]); end
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp [3] = '{4'd1, 4'd3, 4'd9};
    cif.cmd_ready = 1'b0;
    buttons = 11'h20A;
    tick(10);
    buttons = '0;
    tick(2);
    checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", dut.count); end
    cif.cmd_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd_code !== exp[j]) begin errors++; $display("FAIL simul_pop[%0d] got=%b/%0d exp=1/%0d", j, cif.cmd_valid, cif.cmd_code, exp[j]); end
      tick(1);
    end
    checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got=%b exp=0", cif.cmd_valid); end
    cif.cmd_ready = 1'b0;
    tick(30);
  endtask

  task automatic test_overflow;
    cif.cmd_ready = 1'b0;
    buttons = 11'h3F0;
    tick(15);
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", dut.count); end
    checks++; if (dut.pending !== 11'h300) begin errors++; $display("FAIL full_pending got=%h exp=300", dut.pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got=%b exp=0", overflow); end
    buttons[9] = 1'b0;
    tick(10);
    buttons[9] = 1'b1;
    tick(15);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    cif.cmd_ready = 1'b1;
    for (int j = 4; j <= 9; j++) begin
      checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd_code !== 4'(j)) begin errors++; $display("FAIL drain_pop[%0d] got=%b/%0d exp=1/%0d", j, cif.cmd_valid, cif.cmd_code, j); end
      tick(1);
    end
    checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", cif.cmd_valid); end
    buttons = '0;
    cif.cmd_ready = 1'b0;
    tick(30);
  endtask

  task automatic test_reset_mid;
    int first = -1;
    cif.cmd_ready = 1'b0;
    buttons = 11'h030;
    tick(12);
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL mid_count got=%0d exp=2", dut.count); end
    checks++; if (held !== 11'h030) begin errors++; $display("FAIL mid_held got=%h exp=030", held); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", cif.cmd_valid); end
    checks++; if (held !== 11'h0) begin errors++; $display("FAIL async_held got=%h exp=0", held); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got=%b exp=0", overflow); end
    tick(2);
    rst_n = 1'b1;
    for (int n = 1; n <= 20 && first < 0; n++) begin
      tick(1);
      if (cif.cmd_valid === 1'b1) first = n;
    end
    checks++; if (first != 8) begin errors++; $display("FAIL rearm_latency got=%0d exp=8", first); end
    checks++; if (cif.cmd_code !== 4'd4) begin errors++; $display("FAIL rearm_code0 got=%0d exp=4", cif.cmd_code); end
    cif.cmd_ready = 1'b1;
    tick(1);
    checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd_code !== 4'd5) begin errors++; $display("FAIL rearm_code1 got=%b/%0d exp=1/5", cif.cmd_valid, cif.cmd_code); end
    tick(1);
    checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL rearm_empty got=%b exp=0", cif.cmd_valid); end
    buttons = '0;
    tick(20);
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_glitch;
    test_repeat;
    test_simultaneous;
    test_overflow;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pad_command_queue.md
Name: pad_command_queue

Overview:
- Sits downstream of the gamepad `controller` block and consumes its 11-bit `buttonsOut` vector.
- Per button: synchronises, debounces and edge-detects the input. Direction buttons also get hold-to-repeat.
- Resulting button events are queued as 4-bit command codes in a small FIFO with a valid/ready handshake.
- The robot/world logic pops one command per accepted handshake.

Parameters:
- DEBOUNCE_CYCLES, 50000: stable cycles needed before a debounced level changes (1 ms at 50 MHz).
- REPEAT_DELAY, 20000000: held cycles from the first direction event to the first repeat.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeats while a direction is held.
- FIFO_DEPTH, 4: command queue entries; must be a power of 2, ≥2.

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset_key  in  1  reset; asynchronous and active-low.
- buttons_in  in  11  from controller buttonsOut, active-high pressed. Bit map: [0]up [1]down [2]left [3]right [4]A [5]B [6]C [7]X [8]Y [9]Z [10]start.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_code  out  4  command at FIFO head; code = button bit index 0..10.
- cmd_ready  in  1  consumer accepts head when high with cmd_valid.
- held  out  11  debounced button levels.
- overflow  out  1  sticky: an event was lost; cleared only by reset.

Behaviour:
- Reset (reset_key low, async): all flops clear.
  - cmd_valid=0, cmd_code=0, held=0, overflow=0.
  - FIFO empty, pending=0, all counters 0.
- Sync: 2-flop synchroniser per bit; sync latency is 2 cycles.
- Debounce, per bit:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes held.
- Event generation, per bit:
  - An event fires on the cycle the debounced level rises 0→1. No events on release.
- Repeat, bits 0..3 only:
  - Each direction has a repeat counter, cleared on its rising event.
  - While held, the counter counts. An event fires at REPEAT_DELAY cycles after the rising event, then every REPEAT_PERIOD cycles.
  - Release clears the counter immediately.
  - Multiple directions held repeat independently.
- Pending register (11 bits):
  - An event sets its pending bit.
  - An event on a bit that is already pending is lost: the bit stays set and overflow is set to 1.
- Arbitration: each cycle, if the FIFO is not full and pending≠0, the lowest-index pending bit is pushed (code = index) and cleared.
  - At most one push per cycle.
  - Simultaneous events therefore enter the FIFO in ascending index order on consecutive cycles.
- An event and a clear of the same pending bit in the same cycle leave the bit set, with no overflow.
- FIFO:
  - Synchronous; cmd_code is driven from registered head storage.
  - Push-to-cmd_valid latency is 1 cycle.
  - Pop occurs when cmd_valid && cmd_ready.
  - Simultaneous push and pop are allowed in any state, including full. When full, the pop frees a slot in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; a count register of clog2(FIFO_DEPTH)+1 bits tracks occupancy.
  - cmd_code holds its value while cmd_valid=0; consumers ignore it.
- End-to-end latency from the buttons_in edge to cmd_valid, with an empty queue, is exactly 2 + DEBOUNCE_CYCLES + 2 cycles.
- Reset mid-operation discards pending events and FIFO contents. held returns to 0 even if buttons remain pressed; they re-debounce as new presses.

Decomposition:
- Shared package `pad_pkg`:
  - button index constants BTN_UP=0 … BTN_START=10, and NUM_BUTTONS=11;
  - 4-bit cmd_t;
  - default timing constants.
- Sub-module `debounce_bit`: synchroniser + debounce counter + rising pulse, instantiated ×11 via generate.
- FIFO and arbitration stay inline.

Test Plan (use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4):
- Press A (bit4) steady for 40 cycles, cmd_ready=1 → one cmd_code=4, cmd_valid high for exactly 1 cycle, 8 cycles after the edge; no event on release.
- Toggle bit5 high for 2 cycles then low → held[5] stays 0, no command, overflow=0.
- Hold up (bit0) 60 cycles, cmd_ready=1 → code 0 accepted at rising-event cycles t, t+20, t+28, t+36, t+44, t+52; stops on release.
- Press bits 3,1,9 in the same cycle, cmd_ready=0 → FIFO contents 1,3,9 in that order, count=3; then ready=1 pops 1,3,9.
- Hold cmd_ready=0, generate 6 distinct button presses → FIFO holds the first 4 codes, remaining 2 stay pending. A 7th re-event on a pending bit sets overflow=1. Draining delivers all 6 codes in order.
- Assert reset_key low mid-queue with FIFO count=2 → cmd_valid=0, held=0, overflow=0 asynchronously; after release with buttons held, a fresh event arrives after full debounce.
